mem_sched: RTL and testbench
============================

# mem_sched

Request scheduler in front of the byte-serial memory controller. Accepts instruction-fetch (IF), load (LD) and store (ST) requests and grants the single controller port to one requester at a time. Uses fixed priority with an anti-starvation counter for IF. Cancels speculative IF/LD traffic on pipeline flush without corrupting the in-flight controller transaction.

## Interface
- `STARVE_MAX`, default 4: consecutive LD/ST grants tolerated while IF is waiting; must be 1–7.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `rdy` in 1: global enable; low freezes all state and holds all outputs.
- `iFLUSH` in 1: one-cycle pipeline flush pulse.
- `iIF_req` in 1, `iIF_addr` in 32: fetch request; held until `oIF_done`.
- `oIF_done` out 1, `oIF_inst` out 32: one-cycle completion and instruction.
- `iLD_req` in 1, `iLD_addr` in 32, `iLD_len` in 2: load request; len 0=byte, 1=half, 2=word, 3=reserved (treated as word).
- `oLD_done` out 1, `oLD_dt` out 32: completion and zero-extended load data.
- `iST_req` in 1, `iST_addr` in 32, `iST_len` in 2, `iST_dt` in 32: store request.
- `oST_done` out 1: store completion.
- `oMC_en` out 1: controller request, held high for the whole transaction.
- `oMC_ls` out 1: 0=read (IF/LD), 1=write (ST).
- `oMC_len` out 2: IF always 2 (word); LD/ST copy the requester's len.
- `oMC_addr` out 32, `oMC_dt` out 32: latched address and store data.
- `iMC_done` in 1, `iMC_dt` in 32: controller one-cycle completion and read data.

## Operation
- States: IDLE, BUSY, RESP, DRAIN. Owner register: IF/LD/ST. Counter `starve` is 3 bits.
- IDLE, arbitration when `rdy`:
  - If `iIF_req` and `starve==STARVE_MAX`, IF wins.
  - Otherwise priority is ST > LD > IF.
  - The winner's addr/len/dt are latched, owner is set, and the next state is BUSY.
- Counter update at each grant:
  - LD/ST grant with `iIF_req` high: `starve` +1, saturating at STARVE_MAX.
  - IF grant, or any grant with `iIF_req` low: `starve` cleared to 0.
- Flush in IDLE: IF and LD are excluded from that cycle's arbitration. ST may still be granted.
- BUSY: `oMC_en` is high and `oMC_*` are stable. On `iMC_done`, `iMC_dt` is captured and the next state is RESP.
- Load data shaping on capture: len 0 gives `{24'b0, dt[7:0]}`; len 1 gives `{16'b0, dt[15:0]}`; len 2/3 gives full `dt`. IF data is captured unchanged.
- RESP: exactly one of `oIF_done`/`oLD_done`/`oST_done` is high for one cycle, with its data valid. `oMC_en` is low. Next state is IDLE.
- Flush while BUSY with owner IF or LD: next state is DRAIN. `oMC_en` stays high, because the controller cannot abort.
- DRAIN: on `iMC_done`, discard the data, assert no done, and go to IDLE. A flush during DRAIN has no further effect.
- Flush in RESP with owner IF/LD: the done pulse is suppressed; the state still returns to IDLE.
- Owner ST ignores flush in every state.
- `iMC_done` outside BUSY/DRAIN is ignored.
- Reset, asynchronous:
  - State is IDLE; `starve`, owner and all latches are 0.
  - Every output is 0, including `oMC_en`, all done flags and all data buses.

## Timing
- Grant: request seen in IDLE at edge N; `oMC_en` is high from N+1.
- Completion: `iMC_done` sampled at edge K; the done pulse is high during cycle K+1 (RESP); the state is IDLE at K+2.
- Minimum turnaround between consecutive grants is 2 cycles beyond controller latency. The next grant is issued at edge K+2.
- A requester must drop its req in the cycle its done is high. RESP performs no arbitration, so no double grant can occur.
- `iMC_done` in the same cycle as `iFLUSH`, owner IF/LD: the transaction completes normally into RESP, where flush suppression applies if the flush is still asserted. A single-cycle flush therefore lets that result through as done.
- `rdy` low: no transitions and no counter update; `iMC_done` arriving while `rdy` is low is not captured.

## Test plan
- Single fetch: `iIF_req`=1, addr 0x100; controller returns 0x00A00093 after 5 cycles. Expect `oMC_en` high from cycle 1, `oMC_ls`=0, `oMC_len`=2, and `oIF_done`=1 with `oIF_inst`=0x00A00093 exactly one cycle after `iMC_done`.
- Priority: IF, LD and ST asserted together in IDLE. Grant order is ST, then LD, then IF. After the ST/LD grants `starve`=2, and after the IF grant it is 0.
- Starvation, `STARVE_MAX`=4: IF and ST are held continuously while the ST requester re-requests after every done. IF must be the 5th grant.
- Load shaping: LD len 0 and len 1 at 0x2000, with the controller returning 0xDEADBEEF. Expect `oLD_dt`=0x000000EF for the byte load and 0x0000BEEF for the half load.
- Flush mid-fetch: flush 2 cycles into an IF transaction. `oMC_en` stays high until `iMC_done`, no `oIF_done` is produced, and the block is IDLE one cycle later. Repeat with owner ST: `oST_done` is still produced.
- Reset mid-transaction: drive `rst_n` low while BUSY. All outputs go to 0 immediately without waiting for a clock edge. After release, a new request is granted normally.

Source files
------------

// File: rtl/mem_sched.sv
// mem_sched: arbitrates IF / LD / ST requests onto the single byte-serial
// memory controller port. Fixed priority ST > LD > IF, with an anti-starvation
// counter that forces an IF grant after STARVE_MAX consecutive LD/ST grants
// while IF waits. Pipeline flush cancels speculative IF/LD traffic; an
// in-flight controller transaction is always run to completion (DRAIN).
module mem_sched #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdy,
  input  logic        iFLUSH,
  input  logic        iIF_req,
  input  logic [31:0] iIF_addr,
  output logic        oIF_done,
  output logic [31:0] oIF_inst,
  input  logic        iLD_req,
  input  logic [31:0] iLD_addr,
  input  logic [1:0]  iLD_len,
  output logic        oLD_done,
  output logic [31:0] oLD_dt,
  input  logic        iST_req,
  input  logic [31:0] iST_addr,
  input  logic [1:0]  iST_len,
  input  logic [31:0] iST_dt,
  output logic        oST_done,
  output logic        oMC_en,
  output logic        oMC_ls,
  output logic [1:0]  oMC_len,
  output logic [31:0] oMC_addr,
  output logic [31:0] oMC_dt,
  input  logic        iMC_done,
  input  logic [31:0] iMC_dt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_RESP  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OWN_IF = 2'd0,
    OWN_LD = 2'd1,
    OWN_ST = 2'd2
  } owner_t;

  localparam logic [2:0] SMAX = 3'(STARVE_MAX);

  state_t      state_q,   state_d;
  owner_t      owner_q,   owner_d;
  logic [2:0]  starve_q,  starve_d;
  logic        mc_en_q,   mc_en_d;
  logic        mc_ls_q,   mc_ls_d;
  logic [1:0]  mc_len_q,  mc_len_d;
  logic [31:0] mc_addr_q, mc_addr_d;
  logic [31:0] mc_dt_q,   mc_dt_d;
  logic [31:0] rdata_q,   rdata_d;

  logic if_ok, ld_ok, st_ok, starved;
  logic gnt_if, gnt_ld, gnt_st, any_gnt;
  logic flush_eff;

  // Zero-extend load data according to access length (3 is treated as word).
  function automatic logic [31:0] shape_load(input logic [1:0] len,
                                             input logic [31:0] dt);
    logic [31:0] r;
    case (len)
      2'd0:    r = {24'b0, dt[7:0]};
      2'd1:    r = {16'b0, dt[15:0]};
      default: r = dt;
    endcase
    return r;
  endfunction

  // Arbitration: flush removes IF/LD from the current cycle; starvation forces IF.
  always_comb begin
    if_ok   = iIF_req & ~iFLUSH;
    ld_ok   = iLD_req & ~iFLUSH;
    st_ok   = iST_req;
    starved = if_ok && (starve_q == SMAX);
    gnt_st  = ~starved & st_ok;
    gnt_ld  = ~starved & ~st_ok & ld_ok;
    gnt_if  = starved | (if_ok & ~st_ok & ~ld_ok);
    any_gnt = gnt_st | gnt_ld | gnt_if;
  end

  // Next-state, latch and counter logic; everything holds while rdy is low.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    starve_d  = starve_q;
    mc_en_d   = mc_en_q;
    mc_ls_d   = mc_ls_q;
    mc_len_d  = mc_len_q;
    mc_addr_d = mc_addr_q;
    mc_dt_d   = mc_dt_q;
    rdata_d   = rdata_q;
    if (rdy) begin
      case (state_q)
        ST_IDLE: begin
          if (any_gnt) begin
            state_d = ST_BUSY;
            mc_en_d = 1'b1;
            if (gnt_st) begin
              owner_d   = OWN_ST;
              mc_ls_d   = 1'b1;
              mc_len_d  = iST_len;
              mc_addr_d = iST_addr;
              mc_dt_d   = iST_dt;
            end else if (gnt_ld) begin
              owner_d   = OWN_LD;
              mc_ls_d   = 1'b0;
              mc_len_d  = iLD_len;
              mc_addr_d = iLD_addr;
              mc_dt_d   = 32'h0;
            end else begin
              owner_d   = OWN_IF;
              mc_ls_d   = 1'b0;
              mc_len_d  = 2'd2;
              mc_addr_d = iIF_addr;
              mc_dt_d   = 32'h0;
            end
            // IF waiting behind an LD/ST grant ages the counter; otherwise clear.
            if (gnt_if || !iIF_req) begin
              starve_d = 3'd0;
            end else if (starve_q < SMAX) begin
              starve_d = starve_q + 3'd1;
            end
          end
        end
        ST_BUSY: begin
          if (iMC_done) begin
            // Completion wins over a same-cycle flush; RESP may still suppress.
            state_d = ST_RESP;
            mc_en_d = 1'b0;
            if (owner_q == OWN_LD) begin
              rdata_d = shape_load(mc_len_q, iMC_dt);
            end else if (owner_q == OWN_IF) begin
              rdata_d = iMC_dt;
            end
          end else if (iFLUSH && owner_q != OWN_ST) begin
            state_d = ST_DRAIN;
          end
        end
        ST_RESP: begin
          state_d = ST_IDLE;
        end
        ST_DRAIN: begin
          // Controller cannot abort: wait out the transaction, drop its data.
          if (iMC_done) begin
            state_d = ST_IDLE;
            mc_en_d = 1'b0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          mc_en_d = 1'b0;
        end
      endcase
    end
  end

  // State and latch registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWN_IF;
      starve_q  <= 3'd0;
      mc_en_q   <= 1'b0;
      mc_ls_q   <= 1'b0;
      mc_len_q  <= 2'd0;
      mc_addr_q <= 32'h0;
      mc_dt_q   <= 32'h0;
      rdata_q   <= 32'h0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      starve_q  <= starve_d;
      mc_en_q   <= mc_en_d;
      mc_ls_q   <= mc_ls_d;
      mc_len_q  <= mc_len_d;
      mc_addr_q <= mc_addr_d;
      mc_dt_q   <= mc_dt_d;
      rdata_q   <= rdata_d;
    end
  end

  // Done pulses decode RESP; a flush seen during RESP cancels IF/LD results.
  always_comb begin
    flush_eff = rdy & iFLUSH;
    oIF_done  = (state_q == ST_RESP) && (owner_q == OWN_IF) && !flush_eff;
    oLD_done  = (state_q == ST_RESP) && (owner_q == OWN_LD) && !flush_eff;
    oST_done  = (state_q == ST_RESP) && (owner_q == OWN_ST);
  end

  assign oIF_inst = rdata_q;
  assign oLD_dt   = rdata_q;
  assign oMC_en   = mc_en_q;
  assign oMC_ls   = mc_ls_q;
  assign oMC_len  = mc_len_q;
  assign oMC_addr = mc_addr_q;
  assign oMC_dt   = mc_dt_q;

endmodule

// File: tb/tb_mem_sched.sv
// Directed bench for mem_sched: fetch, priority, starvation, load shaping,
// flush handling, rdy stall and asynchronous reset.
module tb_mem_sched;

  logic        clk = 1'b0;
  logic        rst_n, rdy, iFLUSH;
  logic        iIF_req;
  logic [31:0] iIF_addr;
  logic        oIF_done;
  logic [31:0] oIF_inst;
  logic        iLD_req;
  logic [31:0] iLD_addr;
  logic [1:0]  iLD_len;
  logic        oLD_done;
  logic [31:0] oLD_dt;
  logic        iST_req;
  logic [31:0] iST_addr;
  logic [1:0]  iST_len;
  logic [31:0] iST_dt;
  logic        oST_done;
  logic        oMC_en, oMC_ls;
  logic [1:0]  oMC_len;
  logic [31:0] oMC_addr, oMC_dt;
  logic        iMC_done;
  logic [31:0] iMC_dt;

  int total = 0;
  int bad   = 0;

  mem_sched #(.STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .iFLUSH(iFLUSH),
    .iIF_req(iIF_req), .iIF_addr(iIF_addr), .oIF_done(oIF_done), .oIF_inst(oIF_inst),
    .iLD_req(iLD_req), .iLD_addr(iLD_addr), .iLD_len(iLD_len),
    .oLD_done(oLD_done), .oLD_dt(oLD_dt),
    .iST_req(iST_req), .iST_addr(iST_addr), .iST_len(iST_len), .iST_dt(iST_dt),
    .oST_done(oST_done),
    .oMC_en(oMC_en), .oMC_ls(oMC_ls), .oMC_len(oMC_len), .oMC_addr(oMC_addr),
    .oMC_dt(oMC_dt), .iMC_done(iMC_done), .iMC_dt(iMC_dt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Controller completion pulse; afterwards the DUT is in RESP (or IDLE from DRAIN).
  task automatic mc_done(input logic [31:0] d);
    iMC_done = 1'b1;
    iMC_dt   = d;
    step();
    iMC_done = 1'b0;
    iMC_dt   = 32'h0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; rdy = 1'b1; iFLUSH = 1'b0;
    iIF_req = 1'b0; iIF_addr = 32'h0;
    iLD_req = 1'b0; iLD_addr = 32'h0; iLD_len = 2'd0;
    iST_req = 1'b0; iST_addr = 32'h0; iST_len = 2'd0; iST_dt = 32'h0;
    iMC_done = 1'b0; iMC_dt = 32'h0;
    step(); step();
    chk("rst_en", 32'(oMC_en), 32'd0);
    chk("rst_addr", oMC_addr, 32'h0);
    chk("rst_done", {29'd0, oIF_done, oLD_done, oST_done}, 32'd0);
    chk("rst_data", oIF_inst | oLD_dt | oMC_dt, 32'h0);
    rst_n = 1'b1;
    step();

    // Single fetch
    iIF_req = 1'b1; iIF_addr = 32'h100;
    step();
    chk("if_en", 32'(oMC_en), 32'd1);
    chk("if_ls", 32'(oMC_ls), 32'd0);
    chk("if_len", 32'(oMC_len), 32'd2);
    chk("if_addr", oMC_addr, 32'h100);
    for (int i = 0; i < 4; i++) step();
    chk("if_en_hold", 32'(oMC_en), 32'd1);
    chk("if_no_early_done", 32'(oIF_done), 32'd0);
    mc_done(32'h00A00093);
    chk("if_done", 32'(oIF_done), 32'd1);
    chk("if_inst", oIF_inst, 32'h00A00093);
    chk("if_en_resp", 32'(oMC_en), 32'd0);
    iIF_req = 1'b0;
    step();
    chk("if_done_one_cycle", 32'(oIF_done), 32'd0);

    // Priority ST > LD > IF
    iIF_req = 1'b1; iIF_addr = 32'h104;
    iLD_req = 1'b1; iLD_addr = 32'h2000; iLD_len = 2'd2;
    iST_req = 1'b1; iST_addr = 32'h3000; iST_len = 2'd1; iST_dt = 32'h55;
    step();
    chk("pri1_ls", 32'(oMC_ls), 32'd1);
    chk("pri1_addr", oMC_addr, 32'h3000);
    chk("pri1_len", 32'(oMC_len), 32'd1);
    chk("pri1_dt", oMC_dt, 32'h55);
    chk("pri1_starve", 32'(dut.starve_q), 32'd1);
    mc_done(32'h0);
    chk("pri1_st_done", 32'(oST_done), 32'd1);
    iST_req = 1'b0;
    step(); step();
    chk("pri2_addr", oMC_addr, 32'h2000);
    chk("pri2_ls", 32'(oMC_ls), 32'd0);
    chk("pri2_starve", 32'(dut.starve_q), 32'd2);
    mc_done(32'h12345678);
    chk("pri2_ld_done", 32'(oLD_done), 32'd1);
    chk("pri2_ld_dt", oLD_dt, 32'h12345678);
    iLD_req = 1'b0;
    step(); step();
    chk("pri3_addr", oMC_addr, 32'h104);
    chk("pri3_starve", 32'(dut.starve_q), 32'd0);
    mc_done(32'h00000013);
    chk("pri3_if_done", 32'(oIF_done), 32'd1);
    iIF_req = 1'b0;
    step();

    // Starvation with STARVE_MAX=4: IF is the 5th grant
    iIF_req = 1'b1; iIF_addr = 32'h200;
    iST_req = 1'b1; iST_addr = 32'h3100; iST_len = 2'd2; iST_dt = 32'hA5A5A5A5;
    for (int g = 1; g <= 5; g++) begin
      step();
      if (g < 5) begin
        chk($sformatf("starve_g%0d_addr", g), oMC_addr, 32'h3100);
        chk($sformatf("starve_g%0d_cnt", g), 32'(dut.starve_q), 32'(g));
      end else begin
        chk("starve_g5_addr", oMC_addr, 32'h200);
        chk("starve_g5_cnt", 32'(dut.starve_q), 32'd0);
      end
      mc_done(32'h0);
      if (g == 5) begin
        chk("starve_if_done", 32'(oIF_done), 32'd1);
        iIF_req = 1'b0; iST_req = 1'b0;
      end
      step();
    end

    // Load shaping
    iLD_req = 1'b1; iLD_addr = 32'h2000; iLD_len = 2'd0;
    step();
    chk("ldb_len", 32'(oMC_len), 32'd0);
    mc_done(32'hDEADBEEF);
    chk("ldb_done", 32'(oLD_done), 32'd1);
    chk("ldb_dt", oLD_dt, 32'h000000EF);
    iLD_req = 1'b0;
    step();
    iLD_req = 1'b1; iLD_len = 2'd1;
    step();
    chk("ldh_len", 32'(oMC_len), 32'd1);
    mc_done(32'hDEADBEEF);
    chk("ldh_dt", oLD_dt, 32'h0000BEEF);
    iLD_req = 1'b0;
    step();

    // Flush mid-fetch: drain, no done
    iIF_req = 1'b1; iIF_addr = 32'h140;
    step(); step();
    iFLUSH = 1'b1; iIF_req = 1'b0;
    step();
    iFLUSH = 1'b0;
    chk("fl_if_en_drain", 32'(oMC_en), 32'd1);
    step();
    chk("fl_if_en_drain2", 32'(oMC_en), 32'd1);
    mc_done(32'hFFFFFFFF);
    chk("fl_if_no_done", 32'(oIF_done), 32'd0);
    chk("fl_if_en_off", 32'(oMC_en), 32'd0);
    chk("fl_if_discard", oIF_inst, 32'h0000BEEF);
    step();
    chk("fl_if_no_done2", 32'(oIF_done), 32'd0);

    // Flush with owner ST still completes
    iST_req = 1'b1; iST_addr = 32'h3200; iST_len = 2'd2; iST_dt = 32'hCAFEF00D;
    step(); step();
    iFLUSH = 1'b1;
    step();
    iFLUSH = 1'b0;
    chk("fl_st_en", 32'(oMC_en), 32'd1);
    mc_done(32'h0);
    chk("fl_st_done", 32'(oST_done), 32'd1);
    iST_req = 1'b0;
    step();

    // Flush in IDLE blocks LD; flush in RESP suppresses LD done
    iLD_req = 1'b1; iLD_addr = 32'h2400; iLD_len = 2'd2; iFLUSH = 1'b1;
    step();
    chk("fl_idle_no_grant", 32'(oMC_en), 32'd0);
    iFLUSH = 1'b0;
    step();
    chk("fl_idle_grant_after", oMC_addr, 32'h2400);
    mc_done(32'h77);
    iFLUSH = 1'b1;
    #1;
    chk("fl_resp_suppress", 32'(oLD_done), 32'd0);
    iLD_req = 1'b0;
    step();
    iFLUSH = 1'b0;
    chk("fl_resp_idle", 32'(oMC_en), 32'd0);

    // rdy low: iMC_done is not captured
    iIF_req = 1'b1; iIF_addr = 32'h300;
    step();
    rdy = 1'b0; iMC_done = 1'b1; iMC_dt = 32'h99;
    step();
    rdy = 1'b1; iMC_done = 1'b0;
    chk("rdy_no_capture", 32'(oIF_done), 32'd0);
    chk("rdy_en_hold", 32'(oMC_en), 32'd1);
    mc_done(32'h1234);
    chk("rdy_then_done", oIF_inst, 32'h1234);
    iIF_req = 1'b0;
    step();

    // Asynchronous reset mid-transaction
    iIF_req = 1'b1; iIF_addr = 32'h180;
    step();
    chk("arst_busy", 32'(oMC_en), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_en", 32'(oMC_en), 32'd0);
    chk("arst_addr", oMC_addr, 32'h0);
    chk("arst_len", 32'(oMC_len), 32'd0);
    chk("arst_inst", oIF_inst, 32'h0);
    step();
    rst_n = 1'b1;
    step();
    chk("arst_regrant_en", 32'(oMC_en), 32'd1);
    chk("arst_regrant_addr", oMC_addr, 32'h180);
    mc_done(32'h0BADF00D);
    chk("arst_done", oIF_inst, 32'h0BADF00D);
    iIF_req = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
